// File: rtl/pixel_fetch_ctrl.sv
// Pixel ROM read initiator with a first-word fall-through prefetch FIFO and a req/valid pixel port.
// Optional sticky underrun flag is built only when PIXEL_FETCH_UNDERRUN_EN is defined.
module pixel_fetch_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start_in,
  input  logic             pix_req_in,
  output logic [WIDTH-1:0] pix_out,
  output logic             pix_valid_out,
  output logic [AW-1:0]    rom_addr_out,
  output logic             rom_rd_en_out,
  input  logic [WIDTH-1:0] rom_dat_in,
  output logic             underrun_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [CW:0]   FIFO_CAP = (CW + 1)'(FIFO_DEPTH);

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic             run;
  logic             empty;
  logic             rd_en;
  logic             push;
  logic             pop;
  logic [CW:0]      credit;
  logic [WIDTH-1:0] head;

  // A word still in flight holds a FIFO slot, so reads never outrun free space.
  always_comb begin
    run    = (state_q == ST_RUN);
    empty  = (count_q == '0);
    credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    rd_en  = run && (credit < FIFO_CAP);
    head   = empty ? hold_q : fifo_mem[rd_ptr_q];
    push   = inflight_q && !frame_start_in;
    pop    = run && pix_req_in && !empty && !frame_start_in;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_d     = hold_q;
    if (frame_start_in) begin
      // Restart drops everything queued and the word returning from the ROM.
      state_d    = ST_RUN;
      addr_d     = '0;
      inflight_d = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      hold_d     = '0;
    end else begin
      inflight_d = rd_en;
      if (rd_en) begin
        addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      hold_d = head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= rom_dat_in;
    end
  end

`ifdef PIXEL_FETCH_UNDERRUN_EN
  logic underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (frame_start_in) begin
      underrun_d = 1'b0;
    end else if (run && pix_req_in && empty) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_out = underrun_q;
`else
  assign underrun_out = 1'b0;
`endif

  assign pix_out       = head;
  assign pix_valid_out = !empty;
  assign rom_addr_out  = addr_q;
  assign rom_rd_en_out = rd_en;

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Bench for pixel_fetch_ctrl: vector table, directed corner sequences and a random run
// checked against a queue-based model of the fetch/FIFO rules. ROM holds mem[i]=0x10+i.
module tb_pixel_fetch_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int FD    = 4;
`ifdef PIXEL_FETCH_UNDERRUN_EN
  localparam bit UND_EXP = 1'b1;
`else
  localparam bit UND_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start_in = 1'b0;
  logic             pix_req_in = 1'b0;
  logic [WIDTH-1:0] pix_out;
  logic             pix_valid_out;
  logic [3:0]       rom_addr_out;
  logic             rom_rd_en_out;
  logic [WIDTH-1:0] rom_dat = '0;
  logic             underrun_out;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;

  pixel_fetch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start_in (frame_start_in),
    .pix_req_in     (pix_req_in),
    .pix_out        (pix_out),
    .pix_valid_out  (pix_valid_out),
    .rom_addr_out   (rom_addr_out),
    .rom_rd_en_out  (rom_rd_en_out),
    .rom_dat_in     (rom_dat),
    .underrun_out   (underrun_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(int a);
    return 8'(16 + a);
  endfunction

  // Registered ROM: one cycle read latency.
  always_ff @(posedge clk) begin
    if (rom_rd_en_out) rom_dat <= rom_word(int'(rom_addr_out));
  end

  // Reference model: pixels queued, one optional outstanding read, next address.
  int m_q[$];
  bit m_run = 0;
  bit m_infl = 0;
  int m_infl_addr = 0;
  int m_addr = 0;
  int m_last = 0;
  bit m_und = 0;

  function automatic bit m_rd();
    return m_run && ((m_q.size() + int'(m_infl)) < FD);
  endfunction

  function automatic int m_shown();
    return (m_q.size() != 0) ? m_q[0] : m_last;
  endfunction

  function automatic void model_edge(bit rstn, bit fs, bit req);
    bit rd;
    bit vld;
    int shown;
    rd    = m_rd();
    vld   = (m_q.size() != 0);
    shown = m_shown();
    if (!rstn) begin
      m_run = 0; m_q.delete(); m_infl = 0; m_addr = 0; m_last = 0; m_und = 0;
    end else if (fs) begin
      m_run = 1; m_q.delete(); m_infl = 0; m_addr = 0; m_last = 0; m_und = 0;
    end else begin
      if (UND_EXP && m_run && req && !vld) m_und = 1;
      if (req && vld) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(16 + m_infl_addr);
      m_last = shown;
      m_infl = rd;
      if (rd) begin
        m_infl_addr = m_addr;
        m_addr = (m_addr + 1) % DEPTH;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (tick %0d): actual=0x%0h required=0x%0h", name, tick_no, act, req);
    end
  endtask

  task automatic tick(input bit rstn, input bit fs, input bit req);
    rst_n = rstn;
    frame_start_in = fs;
    pix_req_in = req;
    @(posedge clk);
    model_edge(rstn, fs, req);
    #1;
    tick_no++;
    check("model_rd_en", int'(rom_rd_en_out), int'(m_rd()));
    check("model_addr", int'(rom_addr_out), m_addr);
    check("model_valid", int'(pix_valid_out), int'(m_q.size() != 0));
    check("model_pix", int'(pix_out), m_shown());
    check("model_underrun", int'(underrun_out), int'(m_und));
  endtask

  task automatic check_outs(input string name, input bit rd, input int addr, input bit vld,
                            input int pix);
    check({name, "_rd_en"}, int'(rom_rd_en_out), int'(rd));
    check({name, "_addr"}, int'(rom_addr_out), addr);
    check({name, "_valid"}, int'(pix_valid_out), int'(vld));
    check({name, "_pix"}, int'(pix_out), pix);
  endtask

  typedef struct {
    bit rstn; bit fs; bit req;
    bit rd; int addr; bit vld; int pix;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit found;

    // Reset, start, fill without pops, then a few isolated pops.
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 1, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 2, 1, 'h10};
    vecs[4]  = '{1, 0, 0, 1, 3, 1, 'h10};
    vecs[5]  = '{1, 0, 0, 0, 4, 1, 'h10};
    vecs[6]  = '{1, 0, 0, 0, 4, 1, 'h10};
    vecs[7]  = '{1, 0, 0, 0, 4, 1, 'h10};
    vecs[8]  = '{1, 0, 1, 1, 4, 1, 'h11};
    vecs[9]  = '{1, 0, 0, 0, 5, 1, 'h11};
    vecs[10] = '{1, 0, 0, 0, 5, 1, 'h11};
    vecs[11] = '{1, 0, 1, 1, 5, 1, 'h12};

    #1;
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].rstn, vecs[i].fs, vecs[i].req);
      check_outs($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].vld, vecs[i].pix);
    end

    // Idle after reset: nothing moves without a frame start.
    tick(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0);
      check_outs("idle", 0, 0, 0, 0);
    end

    // Continuous stream with address wrap.
    tick(0, 0, 0);
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      check("stream_valid", int'(pix_valid_out), 1);
      check("stream_pix", int'(pix_out), 16 + (i % 16));
      tick(1, 0, 1);
    end
    check("stream_underrun", int'(underrun_out), 0);

    // Restart while the read of address 9 is in flight.
    tick(0, 0, 0);
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (rom_addr_out == 4'd10) begin
        found = 1;
        break;
      end
      tick(1, 0, 1);
    end
    check("restart_reach_addr10", int'(found), 1);
    check("restart_stale_on_bus", int'(rom_dat), 'h19);
    tick(1, 1, 1);
    check_outs("restart_e0", 1, 0, 0, 0);
    tick(1, 0, 0);
    check_outs("restart_e1", 1, 1, 0, 0);
    tick(1, 0, 0);
    check_outs("restart_e2", 1, 2, 1, 'h10);
    tick(1, 0, 1);
    check("restart_second_pix", int'(pix_out), 'h11);

    // Underrun: ignored in IDLE, sticky in RUN, cleared by frame start.
    tick(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1);
      check("und_idle", int'(underrun_out), 0);
    end
    tick(1, 1, 0);
    tick(1, 0, 1);
    check("und_set", int'(underrun_out), int'(UND_EXP));
    tick(1, 0, 0);
    check("und_hold", int'(underrun_out), int'(UND_EXP));
    tick(1, 0, 0);
    check("und_hold2", int'(underrun_out), int'(UND_EXP));
    tick(1, 1, 0);
    check("und_clear", int'(underrun_out), 0);
    tick(1, 1, 1);
    check("und_fs_wins", int'(underrun_out), 0);
    tick(1, 0, 0);
    check("und_after_fs", int'(underrun_out), 0);

    // Reset with three words queued and one read in flight.
    tick(0, 0, 0);
    tick(1, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    check_outs("prerst", 0, 4, 1, 'h10);
    tick(0, 0, 0);
    check_outs("rst_edge", 0, 0, 0, 0);
    check("rst_underrun", int'(underrun_out), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      check_outs("post_rst", 0, 0, 0, 0);
    end

    // Random traffic against the model.
    tick(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit f;
      bit q;
      r = ($urandom_range(0, 299) != 0);
      f = ($urandom_range(0, 39) == 0);
      q = ($urandom_range(0, 9) < 6);
      tick(r, f, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
